// File: rtl/disp_hold_fifo_if.sv
// disp_hold_fifo_if -- groups the CPU write port and the display-side outputs
// of disp_hold_fifo.
//   wr_en / wr_data : CPU output-port write strobe and word
//   disp_data       : word currently shown on the hex display
//   disp_new        : one-cycle pulse when disp_data takes a new word
//   count / full    : words queued behind the displayed one, queue-full flag
//   overflow        : sticky flag, set when a write had to be dropped
// master = CPU/bench side, slave = FIFO side.
`timescale 1ns/1ps
interface disp_hold_fifo_if #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 4
);
  logic                     wr_en;
  logic [DATA_W-1:0]        wr_data;
  logic [DATA_W-1:0]        disp_data;
  logic                     disp_new;
  logic [$clog2(DEPTH):0]   count;
  logic                     full;
  logic                     overflow;

  modport master (
    output wr_en, wr_data,
    input  disp_data, disp_new, count, full, overflow
  );

  modport slave (
    input  wr_en, wr_data,
    output disp_data, disp_new, count, full, overflow
  );
endinterface

// File: rtl/disp_hold_fifo.sv
// disp_hold_fifo -- queues CPU output words and presents each one on the
// hex display for HOLD_CYCLES clocks before moving to the next.
//   clk : single clock, rising edge
//   rst : asynchronous active-high reset; discards all queued words
//   bus : disp_hold_fifo_if.slave (write port in, display/status out)
// Parameters: DATA_W word width, DEPTH queue entries (power of two, >= 2),
// HOLD_CYCLES display time per word (>= 1).
`timescale 1ns/1ps
module disp_hold_fifo #(
  parameter int DATA_W      = 16,
  parameter int DEPTH       = 4,
  parameter int HOLD_CYCLES = 50000000
) (
  input  logic            clk,
  input  logic            rst,
  disp_hold_fifo_if.slave bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  typedef enum logic {IDLE, HOLD} state_t;

  state_t              state_q, state_d;
  logic [HW-1:0]       hold_q, hold_d;
  logic [PW-1:0]       wr_ptr_q, rd_ptr_q;
  logic [DATA_W-1:0]   disp_q;
  logic                new_q;
  logic                ovf_q;
  logic [DATA_W-1:0]   mem [DEPTH];

  logic [PW-1:0]       count;
  logic                full;
  logic                pop;
  logic                push;
  logic                drop;

  // Occupancy comes only from the registered pointers; the extra wrap bit
  // separates full (difference DEPTH) from empty (difference 0).
  assign count = wr_ptr_q - rd_ptr_q;
  assign full  = (count == PW'(DEPTH));

  // Pop decision looks at registered count only, so a word written this
  // cycle can never be popped in the same cycle.
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    pop     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (count != '0) begin
          pop     = 1'b1;
          hold_d  = HW'(HOLD_CYCLES - 1);
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (hold_q != '0) begin
          hold_d = hold_q - 1'b1;
        end else if (count != '0) begin
          pop    = 1'b1;
          hold_d = HW'(HOLD_CYCLES - 1);
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // A same-cycle pop frees a slot, so a full queue still accepts the write.
  assign push = bus.wr_en && (!full || pop);
  assign drop = bus.wr_en && full && !pop;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      hold_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      disp_q   <= '0;
      new_q    <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      new_q   <= pop;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
        disp_q   <= mem[rd_ptr_q[AW-1:0]];
      end
      if (drop) ovf_q <= 1'b1;
    end
  end

  // Storage is not reset; the pointers alone define valid contents.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q[AW-1:0]] <= bus.wr_data;
  end

  assign bus.disp_data = disp_q;
  assign bus.disp_new  = new_q;
  assign bus.count     = count;
  assign bus.full      = full;
  assign bus.overflow  = ovf_q;

endmodule

// File: doc/disp_hold_fifo.md
DISP_HOLD_FIFO -- requirements
Module: disp_hold_fifo

Interface
REQ-001 Parameter DATA_W, default 16, SHALL set the width of one display word (4 hex digits).
REQ-002 Parameter DEPTH, default 4, SHALL set the FIFO entry count; power of two, >= 2.
REQ-003 Parameter HOLD_CYCLES, default 50000000, SHALL set the number of clk cycles each word stays on disp_data; >= 1.
REQ-004 clk  input  1  SHALL be the single clock; all state updates occur on its rising edge.
REQ-005 rst  input  1  SHALL be the asynchronous, active-high reset.
REQ-006 wr_en  input  1  SHALL be the CPU output-port write strobe, one word per high cycle.
REQ-007 wr_data  input  DATA_W  SHALL be the CPU output word, sampled when wr_en=1.
REQ-008 disp_data  output  DATA_W  SHALL be the registered word feeding the hex display.
REQ-009 disp_new  output  1  SHALL pulse for one cycle when disp_data loads a new word.
REQ-010 count  output  clog2(DEPTH)+1  SHALL be the number of words queued, excluding the one displayed.
REQ-011 full  output  1  SHALL be high when count == DEPTH.
REQ-012 overflow  output  1  SHALL be a sticky flag for a dropped write.

Function
REQ-013 Storage SHALL be a circular buffer of DEPTH words; read/write pointers SHALL carry one extra wrap bit; pointers SHALL wrap from DEPTH-1 to 0.
REQ-014 A write SHALL be accepted when wr_en=1 and (count < DEPTH or a pop occurs in the same cycle).
REQ-015 A write with wr_en=1, count == DEPTH and no same-cycle pop SHALL be dropped; it SHALL leave FIFO contents and pointers unchanged and set overflow=1.
REQ-016 Simultaneous accepted push and pop SHALL leave count unchanged.
REQ-017 The controller SHALL have two states, IDLE and HOLD.
REQ-018 In IDLE with count > 0: pop the head, load it into disp_data, assert disp_new, load the hold counter with HOLD_CYCLES-1, and go to HOLD at the next edge.
REQ-019 In IDLE with count == 0: hold disp_data unchanged and stay in IDLE.
REQ-020 In HOLD with hold counter > 0: decrement the counter and perform no pop.
REQ-021 In HOLD with hold counter == 0 and count > 0: pop and load the next word exactly as in REQ-018 and stay in HOLD, giving back-to-back words exactly HOLD_CYCLES cycles apart.
REQ-022 In HOLD with hold counter == 0 and count == 0: go to IDLE and keep disp_data.
REQ-023 There SHALL be no write-through bypass: a write accepted at edge t into an empty FIFO while IDLE SHALL appear on disp_data after edge t+1 (latency 2 edges).
REQ-024 The pop decision SHALL use the registered count, so a same-cycle write cannot be popped in the cycle it is written.
REQ-025 full and count SHALL be registered, or derived combinationally from registered pointers only.
REQ-026 overflow SHALL stay high until reset.

Reset
REQ-027 When rst=1, asynchronously: state = IDLE, pointers = 0, count = 0, hold counter = 0, disp_data = 0, disp_new = 0, overflow = 0, full = 0.
REQ-028 Assertion of rst during HOLD or with queued words SHALL discard all queued words; FIFO RAM contents need not be cleared.
REQ-029 After rst deasserts, wr_en SHALL be honoured from the first rising edge.

Verification (HOLD_CYCLES=4, DEPTH=4, DATA_W=16)
REQ-030 Single write 0x1234 after reset -> disp_data = 0x1234 after 2nd edge, disp_new high for that cycle only, state back to IDLE 4 cycles later, disp_data stays 0x1234.
REQ-031 Burst of 5 writes 0xA001..0xA005 on consecutive cycles -> displayed in order, each held exactly 4 cycles, no overflow (first word popped before fifth write).
REQ-032 Burst of 7 writes with a pop inside the window -> exactly the writes that hit full with no same-cycle pop are dropped, overflow = 1 and remains 1, surviving words are displayed in order.
REQ-033 FIFO full and write coinciding with a HOLD-expiry pop -> write accepted, count stays 4, overflow stays 0.
REQ-034 rst pulse mid-HOLD with 3 words queued -> all outputs 0 immediately (asynchronously), no stale word is ever displayed afterwards, and a subsequent write 0xBEEF displays at latency 2.
REQ-035 More than 2*DEPTH writes paced one per HOLD period -> pointer wrap exercised, every word displayed in order, count never exceeds 1.
